syn_lb_arb: RTL and testbench
=============================

# syn_lb_arb

Local-bus arbiter that shares one downstream local-bus slave port between NUM_MSTR requesters (host bridge, debug/register masters, etc.). It picks requesters round-robin, issues one transaction at a time downstream, and routes the slave response back to the granted requester. If a slave never answers, a watchdog timeout completes the transaction with an error response. It sits between the requesters and the local-bus address decoder/slaves.

## Interface
- NUM_MSTR, 2: number of requesters (2..8)
- DATA_W, 32: local-bus data width
- ADDR_W, 8: local-bus address width
- TIMEOUT, 255: maximum cycles spent in WAIT before an error completion (1..65535)
- clk_ir  in  1  system clock
- rst_ih  in  1  reset: synchronous, active-high, single clock domain
- mst_rd_en  in  NUM_MSTR  per-requester read request (level)
- mst_wr_en  in  NUM_MSTR  per-requester write request (level)
- mst_addr  in  NUM_MSTR*ADDR_W  requester addresses; requester i in bits [i*ADDR_W +: ADDR_W]
- mst_wr_data  in  NUM_MSTR*DATA_W  requester write data, packed the same way
- mst_wr_valid  out  NUM_MSTR  one-cycle write completion, one bit per requester
- mst_rd_valid  out  NUM_MSTR  one-cycle read completion, one bit per requester
- mst_rd_data  out  DATA_W  read data, shared by all requesters; qualify with own mst_rd_valid bit
- lb_rd_en, lb_wr_en  out  1  downstream request pulses
- lb_addr  out  ADDR_W  downstream address
- lb_wr_data  out  DATA_W  downstream write data
- lb_wr_valid, lb_rd_valid  in  1  downstream completions
- lb_rd_data  in  DATA_W  downstream read data
- gnt_id  out  3  index of the current or last granted requester
- timeout_p  out  1  one-cycle pulse when a transaction times out

## Operation
- Requester rule: hold rd_en or wr_en, with addr and wr_data stable, until the requester sees its own valid bit. Drop the request in the cycle after valid.
- If rd_en and wr_en are both high on the same requester, the arbiter performs a write only.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any requester is active, grant the first active index found by searching from rr_ptr+1 (modulo NUM_MSTR) upward.
  - Latch op, addr and wr_data; set rr_ptr = gnt_id; go to ISSUE.
- ISSUE: lb_rd_en or lb_wr_en is high for exactly this one cycle; lb_addr and lb_wr_data come from the latch. Go to WAIT and clear the timer.
- WAIT:
  - The op-matching lb valid (lb_wr_valid for writes, lb_rd_valid for reads) ends the transaction and captures lb_rd_data. Go to DONE.
  - The non-matching valid is ignored.
  - If the timer reaches TIMEOUT first, capture rd_data = DATA_W'hDEADBEEF (truncated), pulse timeout_p, and go to DONE.
  - If the response and timeout occur in the same cycle, the response wins and there is no timeout_p.
- DONE: the granted requester's mst_wr_valid or mst_rd_valid bit is high for exactly this cycle, with mst_rd_data valid. Return to IDLE.
- lb valids arriving in IDLE, ISSUE or DONE are stray: ignored, no output effect.
- Reset values: state IDLE; rr_ptr = NUM_MSTR-1 (requester 0 wins first); gnt_id 0; all valids, lb_*_en and timeout_p 0; lb_addr, lb_wr_data, mst_rd_data 0. Reset in any state aborts the transaction with no completion.
- Timer width: clog2(TIMEOUT+1) bits, saturating. It counts only in WAIT.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: lb_*_en pulse. Slave answers in cycle k≥2. Cycle k+1: mst valid.
- Minimum turnaround is 4 cycles per transaction (IDLE→ISSUE→WAIT→DONE). Back-to-back grants never overlap.
- A timeout completion occurs TIMEOUT+2 cycles after the ISSUE cycle.
- All outputs are registered; there is no combinational path from lb_* inputs to mst_* outputs.

## Structure
- syn_lb_arb_pkg holds:
  - the FSM enum typedef lb_arb_st_t {IDLE, ISSUE, WAIT, DONE}
  - the LB_ARB_ERR_DATA constant 32'hDEADBEEF
- Sub-module syn_rr_arb: parameterised combinational round-robin picker. Inputs: request vector and pointer. Outputs: one-hot grant and index. It is reusable for other shared resources.

## Test plan
- Single write: requester 0 writes addr 8'h10, data 32'h1234_5678; slave answers wr_valid 3 cycles after lb_wr_en → lb_wr_en one cycle with matching addr/data, then mst_wr_valid[0] one cycle later.
- Read data routing: requester 1 reads addr 8'h22; slave returns 32'hCAFE_0001 → mst_rd_valid = 2'b10 with mst_rd_data 32'hCAFE_0001; mst_rd_valid[0] stays 0.
- Round-robin fairness: both requesters hold continuous reads for 6 transactions from reset → grant order 0,1,0,1,0,1.
- Timeout: TIMEOUT = 10, slave silent → timeout_p and mst_rd_valid both fire; mst_rd_data 32'hDEADBEEF 12 cycles after the lb_rd_en cycle; next request is served normally.
- Stray and simultaneous events: lb_rd_valid pulsed in IDLE → no output. Slave response on the exact timeout cycle → normal completion, timeout_p stays 0. rd_en+wr_en together → write only.
- Reset mid-WAIT: assert rst_ih for 1 cycle during WAIT → no completion pulse; all outputs at reset values; requester 0 is granted first afterwards.

Source files
------------

// File: rtl/syn_lb_arb_pkg.sv
// syn_lb_arb_pkg: shared types and constants for the local-bus arbiter.
//   lb_arb_st_t      - arbiter FSM states
//   LB_ARB_ERR_DATA  - read data returned on a watchdog timeout
//   LB_ARB_ID_W      - width of the grant index / round-robin pointer
package syn_lb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } lb_arb_st_t;

  localparam logic [31:0] LB_ARB_ERR_DATA = 32'hDEADBEEF;
  localparam int unsigned LB_ARB_ID_W     = 3;

endpackage

// File: rtl/syn_lb_arb_rr.sv
// syn_rr_arb: combinational round-robin picker.
//   i_req  - request vector, one bit per requester
//   i_ptr  - index of the last winner; search starts at i_ptr+1
//   o_gnt  - one-hot grant (all zero when nothing requests)
//   o_idx  - index of the granted requester (0 when nothing requests)
module syn_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  // Walk offsets from farthest to nearest so the nearest active
  // requester after i_ptr is the last (winning) assignment.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (i_req[j] && (((32'(i_ptr) + off) % NUM_REQ) == j)) begin
          o_gnt    = '0;
          o_gnt[j] = 1'b1;
          o_idx    = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/syn_lb_arb.sv
// syn_lb_arb: round-robin arbiter sharing one local-bus slave port
// between NUM_MSTR requesters, one transaction at a time, with a
// watchdog that completes a silent transaction with error data.
//   clk_ir, rst_ih            - clock, synchronous active-high reset
//   mst_rd_en/mst_wr_en       - per-requester level requests
//   mst_addr/mst_wr_data      - packed per-requester address / write data
//   mst_rd_valid/mst_wr_valid - per-requester one-cycle completions
//   mst_rd_data               - shared read data, qualified by own valid
//   lb_rd_en/lb_wr_en         - downstream one-cycle request pulses
//   lb_addr/lb_wr_data        - downstream address / write data
//   lb_rd_valid/lb_wr_valid   - downstream completions, lb_rd_data
//   gnt_id                    - current or last granted requester
//   timeout_p                 - one-cycle pulse on watchdog completion
module syn_lb_arb
  import syn_lb_arb_pkg::*;
#(
  parameter int unsigned NUM_MSTR = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clk_ir,
  input  logic                       rst_ih,
  input  logic [NUM_MSTR-1:0]        mst_rd_en,
  input  logic [NUM_MSTR-1:0]        mst_wr_en,
  input  logic [NUM_MSTR*ADDR_W-1:0] mst_addr,
  input  logic [NUM_MSTR*DATA_W-1:0] mst_wr_data,
  output logic [NUM_MSTR-1:0]        mst_wr_valid,
  output logic [NUM_MSTR-1:0]        mst_rd_valid,
  output logic [DATA_W-1:0]          mst_rd_data,
  output logic                       lb_rd_en,
  output logic                       lb_wr_en,
  output logic [ADDR_W-1:0]          lb_addr,
  output logic [DATA_W-1:0]          lb_wr_data,
  input  logic                       lb_wr_valid,
  input  logic                       lb_rd_valid,
  input  logic [DATA_W-1:0]          lb_rd_data,
  output logic [2:0]                 gnt_id,
  output logic                       timeout_p
);

  localparam int unsigned ID_W  = LB_ARB_ID_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  lb_arb_st_t          r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_gnt_id;
  logic [NUM_MSTR-1:0] r_gnt_oh;
  logic                r_op_wr;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_lb_rd_en;
  logic                r_lb_wr_en;
  logic [ADDR_W-1:0]   r_lb_addr;
  logic [DATA_W-1:0]   r_lb_wr_data;
  logic [NUM_MSTR-1:0] r_mst_rd_valid;
  logic [NUM_MSTR-1:0] r_mst_wr_valid;
  logic [DATA_W-1:0]   r_mst_rd_data;
  logic                r_timeout_p;

  logic [NUM_MSTR-1:0] w_req;
  logic [NUM_MSTR-1:0] w_gnt_oh;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_resp;

  assign w_req = mst_rd_en | mst_wr_en;

  syn_rr_arb #(
    .NUM_REQ (NUM_MSTR),
    .IDX_W   (ID_W)
  ) u_rr_arb (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx)
  );

  // Fields of the winning requester; write wins when both enables are set.
  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_MSTR; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_wr   = mst_wr_en[i];
        w_sel_addr = mst_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = mst_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the valid matching the latched operation ends the transaction.
  assign w_resp = r_op_wr ? lb_wr_valid : lb_rd_valid;

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      r_state        <= IDLE;
      r_rr_ptr       <= ID_W'(NUM_MSTR - 1);
      r_gnt_id       <= '0;
      r_gnt_oh       <= '0;
      r_op_wr        <= 1'b0;
      r_tmr          <= '0;
      r_lb_rd_en     <= 1'b0;
      r_lb_wr_en     <= 1'b0;
      r_lb_addr      <= '0;
      r_lb_wr_data   <= '0;
      r_mst_rd_valid <= '0;
      r_mst_wr_valid <= '0;
      r_mst_rd_data  <= '0;
      r_timeout_p    <= 1'b0;
    end else begin
      r_lb_rd_en     <= 1'b0;
      r_lb_wr_en     <= 1'b0;
      r_mst_rd_valid <= '0;
      r_mst_wr_valid <= '0;
      r_timeout_p    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_gnt_id     <= w_gnt_idx;
            r_rr_ptr     <= w_gnt_idx;
            r_gnt_oh     <= w_gnt_oh;
            r_op_wr      <= w_sel_wr;
            r_lb_addr    <= w_sel_addr;
            r_lb_wr_data <= w_sel_data;
            r_lb_wr_en   <= w_sel_wr;
            r_lb_rd_en   <= ~w_sel_wr;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_tmr   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // Response is checked before the timer so a same-cycle
          // response completes normally.
          if (w_resp) begin
            if (!r_op_wr) r_mst_rd_data <= lb_rd_data;
            if (r_op_wr) r_mst_wr_valid <= r_gnt_oh;
            else         r_mst_rd_valid <= r_gnt_oh;
            r_state <= DONE;
          end else if (r_tmr == TMR_W'(TIMEOUT)) begin
            r_mst_rd_data <= DATA_W'(LB_ARB_ERR_DATA);
            r_timeout_p   <= 1'b1;
            if (r_op_wr) r_mst_wr_valid <= r_gnt_oh;
            else         r_mst_rd_valid <= r_gnt_oh;
            r_state <= DONE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign lb_rd_en     = r_lb_rd_en;
  assign lb_wr_en     = r_lb_wr_en;
  assign lb_addr      = r_lb_addr;
  assign lb_wr_data   = r_lb_wr_data;
  assign mst_rd_valid = r_mst_rd_valid;
  assign mst_wr_valid = r_mst_wr_valid;
  assign mst_rd_data  = r_mst_rd_data;
  assign gnt_id       = 3'(r_gnt_id);
  assign timeout_p    = r_timeout_p;

endmodule

// File: tb/tb_syn_lb_arb.sv
// Testbench for syn_lb_arb: two requesters, TIMEOUT = 10, scenario
// tasks plus a randomized run against a transaction-level model.
module tb_syn_lb_arb;

  localparam int NM = 2;
  localparam int TO = 10;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_en = '0;
  logic [1:0]  wr_en = '0;
  logic [7:0]  q_a [NM];
  logic [31:0] q_d [NM];
  logic [15:0] addr_bus;
  logic [63:0] data_bus;
  logic [1:0]  mst_wr_valid, mst_rd_valid;
  logic [31:0] mst_rd_data;
  logic        lb_rd_en, lb_wr_en;
  logic [7:0]  lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid = 1'b0;
  logic        lb_rd_valid = 1'b0;
  logic [31:0] lb_rd_data = '0;
  logic [2:0]  gnt_id;
  logic        timeout_p;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = NM - 1;

  assign addr_bus = {q_a[1], q_a[0]};
  assign data_bus = {q_d[1], q_d[0]};

  always #5 clk = ~clk;

  syn_lb_arb #(
    .NUM_MSTR (NM),
    .DATA_W   (32),
    .ADDR_W   (8),
    .TIMEOUT  (TO)
  ) dut (
    .clk_ir       (clk),
    .rst_ih       (rst),
    .mst_rd_en    (rd_en),
    .mst_wr_en    (wr_en),
    .mst_addr     (addr_bus),
    .mst_wr_data  (data_bus),
    .mst_wr_valid (mst_wr_valid),
    .mst_rd_valid (mst_rd_valid),
    .mst_rd_data  (mst_rd_data),
    .lb_rd_en     (lb_rd_en),
    .lb_wr_en     (lb_wr_en),
    .lb_addr      (lb_addr),
    .lb_wr_data   (lb_wr_data),
    .lb_wr_valid  (lb_wr_valid),
    .lb_rd_valid  (lb_rd_valid),
    .lb_rd_data   (lb_rd_data),
    .gnt_id       (gnt_id),
    .timeout_p    (timeout_p)
  );

  // Round-robin rule: first active index after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [1:0] act);
    for (int off = 1; off <= NM; off++) begin
      if (act[(ptr + off) % NM]) return (ptr + off) % NM;
    end
    return -1;
  endfunction

  // Expected completion cycle relative to the lb enable cycle.
  function automatic int exp_done(input int en_c, input int lat);
    if (lat >= 1 && lat <= TO + 1) return en_c + lat + 1;
    return en_c + TO + 2;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rd_en = '0;
    wr_en = '0;
    lb_rd_valid = 1'b0;
    lb_wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = NM - 1;
  endtask

  // Runs one transaction with currently driven requests and a slave that
  // answers lat cycles after the lb enable (-1 = silent); wlat pulses the
  // op-mismatched valid. Records observations only; callers compare.
  task automatic run_txn(input int lat, input int wlat, input logic [31:0] rdat,
                         output int en_c, output int val_c, output int n_en,
                         output logic [2:0] g, output logic w, output logic [7:0] a,
                         output logic [31:0] d, output logic [1:0] rv, output logic [1:0] wv,
                         output logic [31:0] rd, output logic to, output logic to_stray);
    en_c = -1; val_c = -1; n_en = 0; g = '0; w = 1'b0; a = '0; d = '0;
    rv = '0; wv = '0; rd = '0; to = 1'b0; to_stray = 1'b0;
    for (int c = 0; c < 40 && val_c < 0; c++) begin
      @(negedge clk);
      lb_rd_valid = 1'b0;
      lb_wr_valid = 1'b0;
      lb_rd_data  = $urandom;
      if (lb_rd_en || lb_wr_en) begin
        n_en++;
        if (en_c < 0) begin
          en_c = c; g = gnt_id; w = lb_wr_en; a = lb_addr; d = lb_wr_data;
        end
      end
      if (mst_rd_valid != 0 || mst_wr_valid != 0) begin
        val_c = c; rv = mst_rd_valid; wv = mst_wr_valid; rd = mst_rd_data; to = timeout_p;
      end else if (timeout_p) begin
        to_stray = 1'b1;
      end
      if (val_c < 0 && en_c >= 0) begin
        if (lat >= 0 && c == en_c + lat) begin
          if (w) lb_wr_valid = 1'b1;
          else begin lb_rd_valid = 1'b1; lb_rd_data = rdat; end
        end
        if (wlat >= 0 && c == en_c + wlat) begin
          if (w) lb_rd_valid = 1'b1;
          else   lb_wr_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, timeout_p} !== '0) begin n_err++; $display("FAIL reset_pulses got %b exp 0", {lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, timeout_p}); end
    n_cmp++; if ({lb_addr, lb_wr_data, mst_rd_data} !== '0) begin n_err++; $display("FAIL reset_data got %h exp 0", {lb_addr, lb_wr_data, mst_rd_data}); end
    n_cmp++; if (gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_gnt got %0d exp 0", gnt_id); end
  endtask

  task automatic test_single_write();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd; logic [1:0] rv, wv;
    q_a[0] = 8'h10; q_d[0] = 32'h1234_5678; wr_en = 2'b01;
    eg = rr_pick(m_ptr, 2'b01);
    run_txn(3, -1, '0, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    wr_en = '0; m_ptr = eg;
    n_cmp++; if (g !== 3'(eg)) begin n_err++; $display("FAIL wr_gnt got %0d exp %0d", g, eg); end
    n_cmp++; if ({w, a, d} !== {1'b1, 8'h10, 32'h1234_5678}) begin n_err++; $display("FAIL wr_lb got w=%b a=%h d=%h exp w=1 a=10 d=12345678", w, a, d); end
    n_cmp++; if (ne !== 1) begin n_err++; $display("FAIL wr_en_count got %0d exp 1", ne); end
    n_cmp++; if (vc !== ec + 4) begin n_err++; $display("FAIL wr_latency got %0d exp %0d", vc, ec + 4); end
    n_cmp++; if ({wv, rv, to} !== {2'b01, 2'b00, 1'b0}) begin n_err++; $display("FAIL wr_valid got wv=%b rv=%b to=%b exp wv=01 rv=00 to=0", wv, rv, to); end
  endtask

  task automatic test_read_routing();
    int ec, vc, ne, eg, lat; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd; logic [1:0] rv, wv;
    q_a[1] = 8'h22; rd_en = 2'b10; lat = $urandom_range(1, 5);
    eg = rr_pick(m_ptr, 2'b10);
    run_txn(lat, -1, 32'hCAFE_0001, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en = '0; m_ptr = eg;
    n_cmp++; if ({g, w, a} !== {3'(eg), 1'b0, 8'h22}) begin n_err++; $display("FAIL rd_issue got g=%0d w=%b a=%h exp g=%0d w=0 a=22", g, w, a, eg); end
    n_cmp++; if ({rv, wv} !== {2'b10, 2'b00}) begin n_err++; $display("FAIL rd_route got rv=%b wv=%b exp rv=10 wv=00", rv, wv); end
    n_cmp++; if (rd !== 32'hCAFE_0001) begin n_err++; $display("FAIL rd_data got %h exp cafe0001", rd); end
    n_cmp++; if (vc !== exp_done(ec, lat)) begin n_err++; $display("FAIL rd_latency got %0d exp %0d", vc, exp_done(ec, lat)); end
  endtask

  task automatic test_round_robin();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd; logic [1:0] rv, wv;
    do_reset();
    q_a[0] = 8'h01; q_a[1] = 8'h02; rd_en = 2'b11;
    for (int t = 0; t < 6; t++) begin
      eg = rr_pick(m_ptr, 2'b11);
      run_txn($urandom_range(1, 4), -1, $urandom, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
      m_ptr = eg;
      n_cmp++; if (g !== 3'(eg)) begin n_err++; $display("FAIL rr_order[%0d] got %0d exp %0d", t, g, eg); end
      n_cmp++; if (rv !== 2'(1 << eg)) begin n_err++; $display("FAIL rr_valid[%0d] got %b exp %b", t, rv, 2'(1 << eg)); end
    end
    rd_en = '0;
  endtask

  task automatic test_timeout();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd, rdat; logic [1:0] rv, wv;
    q_a[0] = 8'h40; rd_en = 2'b01;
    eg = rr_pick(m_ptr, 2'b01);
    run_txn(-1, -1, '0, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en = '0; m_ptr = eg;
    n_cmp++; if (vc !== ec + TO + 2) begin n_err++; $display("FAIL to_latency got %0d exp %0d", vc, ec + TO + 2); end
    n_cmp++; if ({to, ts, rv} !== {1'b1, 1'b0, 2'b01}) begin n_err++; $display("FAIL to_pulse got to=%b stray=%b rv=%b exp 1 0 01", to, ts, rv); end
    n_cmp++; if (rd !== ERR) begin n_err++; $display("FAIL to_data got %h exp deadbeef", rd); end
    rdat = $urandom; rd_en = 2'b01;
    eg = rr_pick(m_ptr, 2'b01);
    run_txn(2, -1, rdat, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en = '0; m_ptr = eg;
    n_cmp++; if ({to, rv, rd} !== {1'b0, 2'b01, rdat}) begin n_err++; $display("FAIL to_recover got to=%b rv=%b rd=%h exp 0 01 %h", to, rv, rd, rdat); end
  endtask

  task automatic test_stray();
    logic seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if ({mst_rd_valid, mst_wr_valid, lb_rd_en, lb_wr_en, timeout_p} != '0) seen = 1'b1;
      lb_rd_valid = (c % 2 == 0);
      lb_wr_valid = (c % 3 == 0);
      lb_rd_data  = $urandom;
    end
    @(negedge clk);
    if ({mst_rd_valid, mst_wr_valid, lb_rd_en, lb_wr_en, timeout_p} != '0) seen = 1'b1;
    lb_rd_valid = 1'b0; lb_wr_valid = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL stray_idle got activity=%b exp 0", seen); end
    n_cmp++; if (gnt_id !== 3'(m_ptr)) begin n_err++; $display("FAIL stray_gnt got %0d exp %0d", gnt_id, m_ptr); end
  endtask

  task automatic test_exact_timeout();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd, rdat; logic [1:0] rv, wv;
    q_a[1] = 8'h5A; rd_en = 2'b10; rdat = $urandom;
    eg = rr_pick(m_ptr, 2'b10);
    run_txn(TO + 1, -1, rdat, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en = '0; m_ptr = eg;
    n_cmp++; if (vc !== ec + TO + 2) begin n_err++; $display("FAIL edge_latency got %0d exp %0d", vc, ec + TO + 2); end
    n_cmp++; if ({to, ts, rv, rd} !== {1'b0, 1'b0, 2'b10, rdat}) begin n_err++; $display("FAIL edge_resp got to=%b stray=%b rv=%b rd=%h exp 0 0 10 %h", to, ts, rv, rd, rdat); end
  endtask

  task automatic test_wrong_valid();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd, rdat; logic [1:0] rv, wv;
    q_a[0] = 8'h77; rd_en = 2'b01; rdat = $urandom;
    eg = rr_pick(m_ptr, 2'b01);
    run_txn(4, 1, rdat, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en = '0; m_ptr = eg;
    n_cmp++; if (vc !== ec + 5) begin n_err++; $display("FAIL wrongvld_latency got %0d exp %0d", vc, ec + 5); end
    n_cmp++; if ({rv, rd} !== {2'b01, rdat}) begin n_err++; $display("FAIL wrongvld_data got rv=%b rd=%h exp 01 %h", rv, rd, rdat); end
  endtask

  task automatic test_rd_wr_both();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd; logic [1:0] rv, wv;
    q_a[1] = 8'h33; q_d[1] = 32'hA5A5_0F0F; rd_en = 2'b10; wr_en = 2'b10;
    eg = rr_pick(m_ptr, 2'b10);
    run_txn(2, -1, $urandom, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en = '0; wr_en = '0; m_ptr = eg;
    n_cmp++; if ({w, a, d, ne} !== {1'b1, 8'h33, 32'hA5A5_0F0F, 32'd1}) begin n_err++; $display("FAIL both_issue got w=%b a=%h d=%h n=%0d exp 1 33 a5a50f0f 1", w, a, d, ne); end
    n_cmp++; if ({wv, rv} !== {2'b10, 2'b00}) begin n_err++; $display("FAIL both_valid got wv=%b rv=%b exp 10 00", wv, rv); end
  endtask

  task automatic test_reset_mid_wait();
    int ec, vc, ne, eg; logic [2:0] g; logic w, to, ts; logic [7:0] a; logic [31:0] d, rd, rdat; logic [1:0] rv, wv;
    logic seen = 1'b0;
    q_a[0] = 8'h0C; q_a[1] = 8'h1C; rd_en = 2'b11;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (lb_rd_en) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstw_issue got %b exp 1", seen); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = NM - 1;
    n_cmp++; if ({lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, timeout_p, gnt_id} !== '0) begin n_err++; $display("FAIL rstw_ctrl got %b exp 0", {lb_rd_en, lb_wr_en, mst_rd_valid, mst_wr_valid, timeout_p, gnt_id}); end
    n_cmp++; if ({lb_addr, lb_wr_data, mst_rd_data} !== '0) begin n_err++; $display("FAIL rstw_data got %h exp 0", {lb_addr, lb_wr_data, mst_rd_data}); end
    rdat = $urandom;
    eg = rr_pick(m_ptr, 2'b11);
    run_txn(2, -1, rdat, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
    rd_en[eg] = 1'b0; m_ptr = eg;
    n_cmp++; if ({g, vc, rv, rd} !== {3'(eg), ec + 3, 2'(1 << eg), rdat}) begin n_err++; $display("FAIL rstw_after got g=%0d vc=%0d rv=%b rd=%h exp %0d %0d %b %h", g, vc, rv, rd, eg, ec + 3, 2'(1 << eg), rdat); end
    rd_en = '0;
  endtask

  task automatic test_random();
    int ec, vc, ne, eg, lat, evc; logic [2:0] g; logic w, to, ts, ew; logic [7:0] a, ea; logic [31:0] d, rd, rdat, ed, erd; logic [1:0] rv, wv, ev;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NM; i++) begin
        if (!(rd_en[i] || wr_en[i]) && $urandom_range(0, 1) == 1) begin
          int op;
          op = $urandom_range(0, 2);
          q_a[i] = 8'($urandom); q_d[i] = $urandom;
          rd_en[i] = (op != 1); wr_en[i] = (op != 0);
        end
      end
      if ((rd_en | wr_en) == 2'b00) begin
        q_a[0] = 8'($urandom); q_d[0] = $urandom; rd_en[0] = 1'b1;
      end
      lat  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, TO + 1));
      rdat = $urandom;
      eg = rr_pick(m_ptr, rd_en | wr_en);
      ew = wr_en[eg]; ea = q_a[eg]; ed = q_d[eg];
      evc = exp_done(0, lat);
      erd = (lat >= 1) ? rdat : ERR;
      ev  = 2'(1 << eg);
      run_txn(lat, -1, rdat, ec, vc, ne, g, w, a, d, rv, wv, rd, to, ts);
      m_ptr = eg;
      rd_en[eg] = 1'b0; wr_en[eg] = 1'b0;
      n_cmp++; if ({g, w, a, d} !== {3'(eg), ew, ea, ed}) begin n_err++; $display("FAIL rnd_issue[%0d] got g=%0d w=%b a=%h d=%h exp %0d %b %h %h", t, g, w, a, d, eg, ew, ea, ed); end
      n_cmp++; if (ne !== 1) begin n_err++; $display("FAIL rnd_en_count[%0d] got %0d exp 1", t, ne); end
      n_cmp++; if (vc - ec !== evc) begin n_err++; $display("FAIL rnd_latency[%0d] got %0d exp %0d", t, vc - ec, evc); end
      n_cmp++; if ({wv, rv} !== (ew ? {ev, 2'b00} : {2'b00, ev})) begin n_err++; $display("FAIL rnd_valid[%0d] got wv=%b rv=%b exp w=%b bit=%b", t, wv, rv, ew, ev); end
      n_cmp++; if ({to, ts} !== {(lat < 1), 1'b0}) begin n_err++; $display("FAIL rnd_timeout[%0d] got to=%b stray=%b exp %b 0", t, to, ts, (lat < 1)); end
      if (!ew) begin
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rnd_rdata[%0d] got %h exp %h", t, rd, erd); end
      end
    end
    rd_en = '0; wr_en = '0;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      q_a[i] = '0;
      q_d[i] = '0;
    end
    test_reset();
    test_single_write();
    test_read_routing();
    test_round_robin();
    test_timeout();
    test_stray();
    test_exact_timeout();
    test_wrong_valid();
    test_rd_wr_both();
    test_reset_mid_wait();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
